// File: rtl/hack_alu_sequencer.sv
// Multi-cycle control sequencer in front of the Hack ALU: accepts instructions,
// decodes the ALU control word, samples zr/ng and issues writeback/PC strobes.
// Optional jump counter output enabled by defining HACK_SEQ_JUMP_COUNT_EN.
module hack_alu_sequencer #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [5:0]  alu_ctl,
  output logic        alu_am,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic [15:0] a_value,
  output logic        load_a,
  output logic        load_d,
  output logic        write_m,
  output logic        jump,
  output logic        pc_inc,
  output logic        done
`ifdef HACK_SEQ_JUMP_COUNT_EN
  ,
  output logic [15:0] jump_count
`endif
);

  localparam int unsigned IW    = 16;
  localparam int unsigned CTL_W = 6;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zr_q, zr_d;
  logic             ng_q, ng_d;

  logic             instr_ready_q, instr_ready_d;
  logic [CTL_W-1:0] alu_ctl_q, alu_ctl_d;
  logic             alu_am_q, alu_am_d;
  logic [IW-1:0]    a_value_q, a_value_d;
  logic             load_a_q, load_a_d;
  logic             load_d_q, load_d_d;
  logic             write_m_q, write_m_d;
  logic             jump_q, jump_d;
  logic             pc_inc_q, pc_inc_d;
  logic             done_q, done_d;
  logic             accept;
  logic             jump_cond;
`ifdef HACK_SEQ_JUMP_COUNT_EN
  logic [IW-1:0]    jump_count_q, jump_count_d;
`endif

  // State and output registers; reset discards any instruction in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      ir_q          <= '0;
      cnt_q         <= '0;
      zr_q          <= 1'b0;
      ng_q          <= 1'b0;
      instr_ready_q <= 1'b0;
      alu_ctl_q     <= '0;
      alu_am_q      <= 1'b0;
      a_value_q     <= '0;
      load_a_q      <= 1'b0;
      load_d_q      <= 1'b0;
      write_m_q     <= 1'b0;
      jump_q        <= 1'b0;
      pc_inc_q      <= 1'b0;
      done_q        <= 1'b0;
`ifdef HACK_SEQ_JUMP_COUNT_EN
      jump_count_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      cnt_q         <= cnt_d;
      zr_q          <= zr_d;
      ng_q          <= ng_d;
      instr_ready_q <= instr_ready_d;
      alu_ctl_q     <= alu_ctl_d;
      alu_am_q      <= alu_am_d;
      a_value_q     <= a_value_d;
      load_a_q      <= load_a_d;
      load_d_q      <= load_d_d;
      write_m_q     <= write_m_d;
      jump_q        <= jump_d;
      pc_inc_q      <= pc_inc_d;
      done_q        <= done_d;
`ifdef HACK_SEQ_JUMP_COUNT_EN
      jump_count_q  <= jump_count_d;
`endif
    end
  end

  // Next-state, instruction capture, EXEC countdown and flag sampling.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    zr_d    = zr_q;
    ng_d    = ng_q;
    accept  = instr_valid & instr_ready_q & (state_q == S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ir_q[15]) begin
          cnt_d   = CNT_W'(EXEC_CYCLES - 1);
          state_d = S_EXEC;
        end else begin
          state_d = S_WB;
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          zr_d    = alu_zr;
          ng_d    = alu_ng;
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs are precomputed from the state being entered.
  always_comb begin
    instr_ready_d = 1'b0;
    alu_ctl_d     = '0;
    alu_am_d      = 1'b0;
    a_value_d     = '0;
    load_a_d      = 1'b0;
    load_d_d      = 1'b0;
    write_m_d     = 1'b0;
    jump_d        = 1'b0;
    pc_inc_d      = 1'b0;
    done_d        = 1'b0;
    jump_cond     = (ir_d[2] & ng_d) | (ir_d[1] & zr_d) | (ir_d[0] & ~ng_d & ~zr_d);
`ifdef HACK_SEQ_JUMP_COUNT_EN
    jump_count_d  = jump_count_q;
`endif
    case (state_d)
      S_IDLE: begin
        instr_ready_d = 1'b1;
      end
      S_DECODE, S_EXEC: begin
        if (ir_d[15]) begin
          alu_ctl_d = ir_d[11:6];
          alu_am_d  = ir_d[12];
        end
      end
      S_WB: begin
        done_d = 1'b1;
        if (ir_d[15]) begin
          alu_ctl_d = ir_d[11:6];
          alu_am_d  = ir_d[12];
          load_a_d  = ir_d[5];
          load_d_d  = ir_d[4];
          write_m_d = ir_d[3];
          jump_d    = jump_cond;
          pc_inc_d  = ~jump_cond;
        end else begin
          load_a_d  = 1'b1;
          a_value_d = {1'b0, ir_d[14:0]};
          pc_inc_d  = 1'b1;
        end
      end
      default: begin
        instr_ready_d = 1'b0;
      end
    endcase
`ifdef HACK_SEQ_JUMP_COUNT_EN
    if (jump_d && (jump_count_q != 16'hFFFF)) begin
      jump_count_d = jump_count_q + IW'(1);
    end
`endif
  end

  assign instr_ready = instr_ready_q;
  assign alu_ctl     = alu_ctl_q;
  assign alu_am      = alu_am_q;
  assign a_value     = a_value_q;
  assign load_a      = load_a_q;
  assign load_d      = load_d_q;
  assign write_m     = write_m_q;
  assign jump        = jump_q;
  assign pc_inc      = pc_inc_q;
  assign done        = done_q;
`ifdef HACK_SEQ_JUMP_COUNT_EN
  assign jump_count  = jump_count_q;
`endif

endmodule
